// File: rtl/pipe_pkg.sv
// Shared types and ID/EX field layout for the pipeline stage registers.
// The control bits sit at the bottom of the payload so a flush can clear them.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_e;

  localparam int IDEX_CTRL_W  = 8;
  localparam int IDEX_W       = 150;

  localparam int EXE_CMD_LSB  = 0;
  localparam int EXE_CMD_W    = 3;
  localparam int S_BIT        = 3;
  localparam int B_BIT        = 4;
  localparam int MEM_W_EN_BIT = 5;
  localparam int MEM_R_EN_BIT = 6;
  localparam int WB_EN_BIT    = 7;

  localparam int VAL_RN_LSB   = 8;
  localparam int VAL_RM_LSB   = 40;
  localparam int ST_VAL_LSB   = 72;
  localparam int DEST_LSB     = 104;
  localparam int DEST_W       = 4;
  localparam int IMM_BIT      = 108;
  localparam int SHIFT_LSB    = 109;
  localparam int SHIFT_W      = 9;
  localparam int PC_LSB       = 118;
  localparam int PC_W         = 32;

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating event counter for performance monitoring.
// Counts up on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: step only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with valid/ready, optional skid entry,
// flush of control bits, freeze, and stall/flush performance counters.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  st_e               st_d;
  st_e               st_q;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] s_q;
  logic              in_fire;
  logic              out_fire;
  logic              room;

  assign room = (SKID != 0) ? (st_q != ST_FULL)
                            : ((st_q == ST_EMPTY) || out_ready);

  assign in_ready  = !rst && !flush && !freeze && room;
  assign out_valid = (st_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !freeze && !flush;
  assign out_data  = m_q;

  // Occupancy decode from the state.
  always_comb begin
    occupancy = 2'd0;
    unique case (st_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next state and head register; flush wins over freeze and traffic.
  always_comb begin
    st_d = st_q;
    m_d  = m_q;
    if (flush) begin
      st_d             = ST_EMPTY;
      m_d[CTRL_W-1:0]  = '0;
    end else if (!freeze) begin
      unique case (st_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_d  = in_data;
            st_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            st_d = ST_FULL;
          end else if (out_fire) begin
            st_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            m_d  = s_q;
            st_d = ST_ONE;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  // State and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_EMPTY;
      m_q  <= '0;
    end else begin
      st_q <= st_d;
      m_q  <= m_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] s_d;
    logic [DATA_W-1:0] s_r;

    // Skid entry loads when the head is busy and nothing drains.
    always_comb begin
      s_d = s_r;
      if (flush) begin
        s_d[CTRL_W-1:0] = '0;
      end else if (st_q == ST_ONE && in_fire && !out_fire) begin
        s_d = in_data;
      end
    end

    // Skid register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_r <= '0;
      end else begin
        s_r <= s_d;
      end
    end

    assign s_q = s_r;
  end else begin : g_noskid
    assign s_q = '0;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_fire && !flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush && (st_q != ST_EMPTY)),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus a random
// valid/ready/freeze/flush run against a queue model (skid and no-skid).
module tb_pipe_stage_skid_reg;

  localparam int DW = 150;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          freeze;
  logic          flush;

  logic          o1_ir, o1_ov;
  logic [DW-1:0] o1_od;
  logic [1:0]    o1_occ;
  logic [15:0]   o1_sc, o1_fc;

  logic          o4_ir, o4_ov;
  logic [DW-1:0] o4_od;
  logic [1:0]    o4_occ;
  logic [3:0]    o4_sc, o4_fc;

  logic          o0_ir, o0_ov;
  logic [DW-1:0] o0_od;
  logic [1:0]    o0_occ;
  logic [15:0]   o0_sc, o0_fc;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq [2][$];
  int            msc [2];
  int            mfc [2];
  bit            mif [2];
  bit            mof [2];
  bit            mfl [2];

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_ir),
    .in_data(in_data), .out_valid(o1_ov), .out_ready(out_ready),
    .out_data(o1_od), .freeze(freeze), .flush(flush),
    .occupancy(o1_occ), .stall_cnt(o1_sc), .flush_cnt(o1_fc)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o4_ir),
    .in_data(in_data), .out_valid(o4_ov), .out_ready(out_ready),
    .out_data(o4_od), .freeze(freeze), .flush(flush),
    .occupancy(o4_occ), .stall_cnt(o4_sc), .flush_cnt(o4_fc)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_ir),
    .in_data(in_data), .out_valid(o0_ov), .out_ready(out_ready),
    .out_data(o0_od), .freeze(freeze), .flush(flush),
    .occupancy(o0_occ), .stall_cnt(o0_sc), .flush_cnt(o0_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Checks one instance against the queue model and records what the
  // spec's handshake rules say should fire at the coming edge.
  task automatic model_check(input int k, input bit skid, input logic ir,
                             input logic ov, input logic [1:0] occ,
                             input logic [DW-1:0] od,
                             input logic [15:0] sc, input logic [15:0] fc);
    int  n;
    bit  rdy;
    bit  v;
    n   = mq[k].size();
    rdy = !flush && !freeze &&
          (skid ? (n < 2) : (n == 0 || out_ready));
    v   = (n > 0);
    chk($sformatf("rnd%0d_in_ready", k), DW'(ir), DW'(rdy));
    chk($sformatf("rnd%0d_out_valid", k), DW'(ov), DW'(v));
    chk($sformatf("rnd%0d_occupancy", k), DW'(occ), DW'(n));
    if (v) chk($sformatf("rnd%0d_out_data", k), od, mq[k][0]);
    chk($sformatf("rnd%0d_stall_cnt", k), DW'(sc),
        DW'((msc[k] > 65535) ? 65535 : msc[k]));
    chk($sformatf("rnd%0d_flush_cnt", k), DW'(fc),
        DW'((mfc[k] > 65535) ? 65535 : mfc[k]));
    mif[k] = in_valid && rdy;
    mof[k] = v && out_ready && !freeze && !flush;
    mfl[k] = flush;
    if (v && !mof[k] && !flush) msc[k]++;
    if (flush && v) mfc[k]++;
  endtask

  task automatic model_update(input int k, input logic [DW-1:0] d);
    if (mfl[k]) begin
      mq[k].delete();
    end else begin
      if (mof[k]) void'(mq[k].pop_front());
      if (mif[k]) mq[k].push_back(d);
    end
  endtask

  initial begin
    logic [DW-1:0]  p1;
    logic [DW-1:0]  p2;
    logic [DW-1:0]  e;
    logic [DW-1:0]  dsent;
    logic [159:0]   r;
    logic [15:0]    mid;

    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_out_valid", DW'(o1_ov), '0);
    chk("rst_out_data", o1_od, '0);
    chk("rst_occupancy", DW'(o1_occ), '0);
    chk("rst_in_ready", DW'(o1_ir), '0);
    chk("rst_stall_cnt", DW'(o1_sc), '0);
    tick();
    rst = 1'b0;

    // 1: streaming with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      #1;
      chk("s1_in_ready", DW'(o1_ir), DW'(1));
      tick();
      chk($sformatf("s1_out_data%0d", i), o1_od, DW'(i));
      chk("s1_occupancy", DW'(o1_occ), DW'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("s1_drained", DW'(o1_occ), DW'(0));
    chk("s1_stall_cnt", DW'(o1_sc), DW'(0));

    // 2: backpressure fills the skid entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('hA);
    tick();
    in_data = DW'('hB);
    #1;
    chk("s2_ready_one", DW'(o1_ir), DW'(1));
    tick();
    in_data = DW'('hC);
    #1;
    chk("s2_occ_full", DW'(o1_occ), DW'(2));
    chk("s2_ready_full", DW'(o1_ir), DW'(0));
    chk("s2_head_a", o1_od, DW'('hA));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("s2_head_b", o1_od, DW'('hB));
    chk("s2_occ_one", DW'(o1_occ), DW'(1));
    tick();
    chk("s2_occ_empty", DW'(o1_occ), DW'(0));
    chk("s2_stall_cnt", DW'(o1_sc), DW'(1));

    // 3: flush together with freeze and a pending input
    do_reset();
    p1 = '0; p1[23:8] = 16'hABCD; p1[7:0] = 8'hFF;
    p2 = '0; p2[23:8] = 16'h1234; p2[7:0] = 8'hFF;
    in_valid = 1'b1;
    in_data  = p1;
    tick();
    in_data = p2;
    tick();
    chk("s3_occ_full", DW'(o1_occ), DW'(2));
    flush    = 1'b1;
    freeze   = 1'b1;
    in_data  = DW'('h5555);
    #1;
    chk("s3_ready_flush", DW'(o1_ir), DW'(0));
    tick();
    e = p1;
    e[7:0] = 8'h00;
    chk("s3_out_valid", DW'(o1_ov), DW'(0));
    chk("s3_occupancy", DW'(o1_occ), DW'(0));
    chk("s3_out_data", o1_od, e);
    mid = o1_od[23:8];
    chk("s3_upper_bits", DW'(mid), DW'(16'hABCD));
    chk("s3_flush_cnt", DW'(o1_fc), DW'(1));
    chk("s3_stall_cnt", DW'(o1_sc), DW'(1));
    flush    = 1'b0;
    freeze   = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("s3_not_captured", DW'(o1_occ), DW'(0));

    // 4: freeze holds a single entry
    do_reset();
    in_valid = 1'b1;
    in_data  = DW'('h77);
    tick();
    freeze    = 1'b1;
    in_data   = DW'('h88);
    out_ready = 1'b1;
    #1;
    chk("s4_ready_frozen", DW'(o1_ir), DW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_hold_data", o1_od, DW'('h77));
      chk("s4_hold_occ", DW'(o1_occ), DW'(1));
    end
    chk("s4_stall_cnt", DW'(o1_sc), DW'(3));
    freeze   = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("s4_released", DW'(o1_occ), DW'(0));
    chk("s4_stall_after", DW'(o1_sc), DW'(3));

    // 5: counter saturation, then async reset mid-burst
    do_reset();
    in_valid = 1'b1;
    in_data  = DW'('h99);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("s5_sat4", DW'(o4_sc), DW'(15));
    chk("s5_cnt16", DW'(o1_sc), DW'(20));
    #2;
    rst = 1'b1;
    #1;
    chk("s5_arst_valid", DW'(o1_ov), '0);
    chk("s5_arst_data", o1_od, '0);
    chk("s5_arst_occ", DW'(o1_occ), '0);
    chk("s5_arst_ready", DW'(o1_ir), '0);
    chk("s5_arst_stall", DW'(o1_sc), '0);
    chk("s5_arst_stall4", DW'(o4_sc), '0);
    tick();
    rst = 1'b0;

    // 6: no-skid in_ready tracks out_ready; skid build does not
    in_valid = 1'b1;
    in_data  = DW'('h42);
    tick();
    in_valid = 1'b0;
    #1;
    chk("s6_ns_ready_lo", DW'(o0_ir), DW'(0));
    chk("s6_sk_ready_lo", DW'(o1_ir), DW'(1));
    out_ready = 1'b1;
    #1;
    chk("s6_ns_ready_hi", DW'(o0_ir), DW'(1));
    tick();
    chk("s6_ns_empty", DW'(o0_occ), DW'(0));

    // 6b: random traffic against the queue model, both builds
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      msc[k] = int'(k == 1 ? o1_sc : o0_sc);
      mfc[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      dsent     = r[DW-1:0];
      in_data   = dsent;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 49) < 2);
      #1;
      model_check(1, 1'b1, o1_ir, o1_ov, o1_occ, o1_od, o1_sc, o1_fc);
      model_check(0, 1'b0, o0_ir, o0_ov, o0_occ, o0_od, o0_sc, o0_fc);
      tick();
      model_update(1, dsent);
      model_update(0, dsent);
      if (o0_occ > 2'd1) chk("s6_ns_occ_max", DW'(o0_occ), DW'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
